hawk_axiwr_arb: RTL and testbench
=================================

// Module: hawk_axiwr_arb
// PURPOSE
//  Round-robin arbiter sharing the single hawk AXI write master among NUM_REQ write clients
//  (pgwr_mngr, tol updater, zspage writer). Only one write is outstanding at any time.
//  For the granted client, the block drives one axi_wr_reqpkt_t, tracks the AW and W
//  handshakes independently, waits for B, and returns a one-cycle done pulse and bresp.
//  It also runs a B-channel watchdog.
// PARAMETERS
//  NUM_REQ      3     number of write clients (2..8)
//  B_TIMEOUT    1024  cycles allowed in WAIT_B before wd_err is set; 0 disables the watchdog
// PORTS
//  clk_i        in   1                     clock
//  rst_ni       in   1                     async active-low reset
//  req_i        in   NUM_REQ               per-client write request; held high until done_o
//  pld_i        in   NUM_REQ x axi_wr_pld_t  per-client addr/data/strb; held stable while req high
//  gnt_o        out  NUM_REQ               onehot grant, high from ISSUE until done
//  done_o       out  NUM_REQ               one-cycle pulse to owner when B is accepted
//  bresp_o      out  1                     bresp of completed write, valid with done_o
//  wr_req_o     out  axi_wr_reqpkt_t       to axiwr master (addr,data,strb,awvalid,wvalid)
//  wr_rdy_i     in   axi_wr_rdypkt_t       awready,wready
//  wr_resp_i    in   axi_wr_resppkt_t      bresp,bvalid
//  bready_o     out  1                     high only in WAIT_B
//  busy_o       out  1                     state != IDLE
//  wd_err_o     out  1                     sticky watchdog error; cleared only by reset
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state=IDLE, rr_ptr=0, all outputs 0, wr_req_o='0, aw_done/w_done=0.
//    Reset mid-transaction abandons the write with no done pulse.
//  - FSM IDLE -> ISSUE -> WAIT_B -> IDLE.
//  - IDLE: if |req_i, pick the first requester at or after rr_ptr (wrapping modulo NUM_REQ).
//    Register owner, gnt_o[owner]=1, latch pld_i[owner] into wr_req_o. Go to ISSUE.
//    awvalid/wvalid are first high in the next cycle (1-cycle req->valid latency).
//  - ISSUE: awvalid = ~aw_done, wvalid = ~w_done.
//    aw_done sets on awvalid&awready; w_done sets on wvalid&wready. Both may occur in the same
//    cycle or in either order. addr/data/strb stay constant until both handshakes are done.
//    When (aw_done|aw_hs)&(w_done|w_hs), go to WAIT_B.
//  - WAIT_B: bready_o=1, watchdog counter increments. On bvalid: done_o[owner]=1 for one cycle,
//    bresp_o=bresp, gnt_o cleared, rr_ptr=owner+1 (wraps NUM_REQ-1 -> 0), flags cleared, go to IDLE.
//  - No back-to-back grant in the same cycle as done. The earliest next awvalid is 2 cycles
//    after done.
//  - bvalid outside WAIT_B is ignored; bready stays 0.
//  - Watchdog: counter=B_TIMEOUT-1 in WAIT_B sets wd_err_o (sticky). The FSM keeps waiting;
//    the B_TIMEOUT-th WAIT_B cycle without bvalid sets the flag.
//  - A requester dropping req_i while granted is a protocol violation: the transaction still
//    completes and done still pulses. The bench flags this with an assertion.
//  - Simultaneous requests resolve purely by rr_ptr rotation; there are no static priorities.
// STRUCTURE
//  - hacd_pkg: axi_wr_pld_t, axi_wr_reqpkt_t, axi_wr_rdypkt_t, axi_wr_resppkt_t (existing),
//    plus new typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_B} hawk_wrarb_state_t.
//  - Sub-module hawk_rr_picker: combinational req vector + rr_ptr -> onehot grant and index.
//    It is reusable later for the read-side arbiter.
//  - Owner index width is clogb2(NUM_REQ). Watchdog counter width is clogb2(B_TIMEOUT)+1.
// TESTING
//  - Single write: req_i=3'b001, addr 64'hFFF6100000, awready=wready=1, bvalid 3 cycles later
//    -> awvalid at cycle 1, done_o=3'b001 one cycle, busy_o low next cycle.
//  - Contention: req_i=3'b111 held -> grant order 0,1,2,0. Pointer after client 2 wraps to 0.
//  - Split handshake: wready at cycle 2, awready at cycle 5 -> wvalid drops after cycle 2,
//    awvalid stays high to cycle 5, and WAIT_B is entered at cycle 6.
//  - Stray B: bvalid pulsed in IDLE and in ISSUE -> no done_o, bready_o=0, state unchanged.
//  - Watchdog: B_TIMEOUT=16, bvalid withheld -> wd_err_o=1 after 16 WAIT_B cycles.
//    A late bvalid still completes and wd_err_o stays 1.
//  - Reset mid-op: rst_ni low during ISSUE -> all outputs 0 asynchronously, and the next
//    request is served from rr_ptr=0.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared hawk AXI write-side packet types, arbiter state encoding and width helper.
package hacd_pkg;

  localparam int unsigned AXI_AW = 64;
  localparam int unsigned AXI_DW = 64;
  localparam int unsigned AXI_SW = AXI_DW / 8;

  typedef struct packed {
    logic [AXI_AW-1:0] addr;
    logic [AXI_DW-1:0] data;
    logic [AXI_SW-1:0] strb;
  } axi_wr_pld_t;

  typedef struct packed {
    logic [AXI_AW-1:0] addr;
    logic [AXI_DW-1:0] data;
    logic [AXI_SW-1:0] strb;
    logic              awvalid;
    logic              wvalid;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  typedef struct packed {
    logic bresp;
    logic bvalid;
  } axi_wr_resppkt_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_B} hawk_wrarb_state_t;

  // ceil(log2(n)), never less than 1 so it is always usable as a vector width
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned w;
    w = 0;
    if (n > 1) begin
      for (int unsigned v = n - 1; v > 0; v = v >> 1) w++;
    end
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/hawk_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module hawk_rr_picker
  import hacd_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IW      = clogb2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hawk_axiwr_arb.sv
// Round-robin arbiter sharing the hawk AXI write master among NUM_REQ clients,
// one outstanding write at a time, with a sticky B-channel watchdog.
module hawk_axiwr_arb
  import hacd_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned B_TIMEOUT = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic            [NUM_REQ-1:0]  req_i,
  input  axi_wr_pld_t     [NUM_REQ-1:0]  pld_i,
  output logic            [NUM_REQ-1:0]  gnt_o,
  output logic            [NUM_REQ-1:0]  done_o,
  output logic                           bresp_o,
  output axi_wr_reqpkt_t                 wr_req_o,
  input  axi_wr_rdypkt_t                 wr_rdy_i,
  input  axi_wr_resppkt_t                wr_resp_i,
  output logic                           bready_o,
  output logic                           busy_o,
  output logic                           wd_err_o
);

  localparam int unsigned IW      = clogb2(NUM_REQ);
  localparam int unsigned CW      = clogb2(B_TIMEOUT) + 1;
  localparam int unsigned WD_LAST = (B_TIMEOUT == 0) ? 0 : B_TIMEOUT - 1;
  localparam logic        WD_EN   = (B_TIMEOUT != 0);

  hawk_wrarb_state_t    state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic                 pick_valid;
  logic                 aw_done;
  logic                 w_done;
  logic                 aw_hs;
  logic                 w_hs;
  logic [CW-1:0]        wd_cnt;
  logic [IW-1:0]        ptr_next;

  hawk_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req   (req_i),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign aw_hs    = wr_req_o.awvalid & wr_rdy_i.awready;
  assign w_hs     = wr_req_o.wvalid & wr_rdy_i.wready;
  assign ptr_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      gnt_o    <= '0;
      done_o   <= '0;
      bresp_o  <= 1'b0;
      wr_req_o <= '0;
      bready_o <= 1'b0;
      busy_o   <= 1'b0;
      wd_err_o <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      done_o <= '0;
      unique case (state)
        ARB_IDLE: begin
          // Holding off while done_o is high keeps the finishing client from being regranted
          if (pick_valid && (done_o == '0)) begin
            state            <= ARB_ISSUE;
            owner            <= pick_idx;
            gnt_o            <= pick_gnt;
            busy_o           <= 1'b1;
            wr_req_o.addr    <= pld_i[pick_idx].addr;
            wr_req_o.data    <= pld_i[pick_idx].data;
            wr_req_o.strb    <= pld_i[pick_idx].strb;
            wr_req_o.awvalid <= 1'b1;
            wr_req_o.wvalid  <= 1'b1;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
          end
        end
        ARB_ISSUE: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state            <= ARB_WAIT_B;
            bready_o         <= 1'b1;
            wd_cnt           <= '0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            wr_req_o.awvalid <= 1'b0;
            wr_req_o.wvalid  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_done          <= 1'b1;
              wr_req_o.awvalid <= 1'b0;
            end
            if (w_hs) begin
              w_done          <= 1'b1;
              wr_req_o.wvalid <= 1'b0;
            end
          end
        end
        ARB_WAIT_B: begin
          if (wr_resp_i.bvalid) begin
            state    <= ARB_IDLE;
            done_o   <= gnt_o;
            bresp_o  <= wr_resp_i.bresp;
            gnt_o    <= '0;
            busy_o   <= 1'b0;
            bready_o <= 1'b0;
            rr_ptr   <= ptr_next;
          end else begin
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
            if (WD_EN && (wd_cnt == CW'(WD_LAST))) wd_err_o <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hawk_axiwr_arb.sv
// Directed self-checking bench for hawk_axiwr_arb (3 clients, B_TIMEOUT=16).
module tb_hawk_axiwr_arb;
  import hacd_pkg::*;

  logic                          clk_i = 1'b0;
  logic                          rst_ni = 1'b0;
  logic            [2:0]         req_i;
  axi_wr_pld_t     [2:0]         pld_i;
  logic            [2:0]         gnt_o;
  logic            [2:0]         done_o;
  logic                          bresp_o;
  axi_wr_reqpkt_t                wr_req_o;
  axi_wr_rdypkt_t                wr_rdy_i;
  axi_wr_resppkt_t               wr_resp_i;
  logic                          bready_o;
  logic                          busy_o;
  logic                          wd_err_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [63:0] A0 = 64'hFFF6100000;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_2000;
  localparam logic [63:0] A2 = 64'h0000_0000_0000_3000;

  hawk_axiwr_arb #(
    .NUM_REQ   (3),
    .B_TIMEOUT (16)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .pld_i     (pld_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .bresp_o   (bresp_o),
    .wr_req_o  (wr_req_o),
    .wr_rdy_i  (wr_rdy_i),
    .wr_resp_i (wr_resp_i),
    .bready_o  (bready_o),
    .busy_o    (busy_o),
    .wd_err_o  (wd_err_o)
  );

  always #5 clk_i = ~clk_i;

  // A granted client must keep its request up until done
  a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni) ((gnt_o & ~req_i) == 3'b000))
    else $error("FAIL req_hold: gnt %b req %b", gnt_o, req_i);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  // Waits for a grant, completes both handshakes at once, returns B and checks done
  task automatic serve(input string tag, input logic [2:0] exp_gnt, input logic [63:0] exp_addr,
                       input int unsigned exp_wait);
    int unsigned n;
    n = 0;
    while (gnt_o == 3'b000 && n < 10) begin
      cyc();
      n++;
    end
    check({tag, ":wait"}, 64'(n), 64'(exp_wait));
    check({tag, ":gnt"}, 64'(gnt_o), 64'(exp_gnt));
    check({tag, ":awvalid"}, 64'(wr_req_o.awvalid), 64'd1);
    check({tag, ":addr"}, wr_req_o.addr, exp_addr);
    wr_rdy_i = '1;
    cyc();
    wr_rdy_i = '0;
    check({tag, ":bready"}, 64'(bready_o), 64'd1);
    wr_resp_i = '{bresp: 1'b0, bvalid: 1'b1};
    cyc();
    wr_resp_i = '0;
    check({tag, ":done"}, 64'(done_o), 64'(exp_gnt));
    cyc();
    check({tag, ":gap_gnt"}, 64'(gnt_o), 64'd0);
    check({tag, ":gap_awvalid"}, 64'(wr_req_o.awvalid), 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    req_i     = '0;
    wr_rdy_i  = '0;
    wr_resp_i = '0;
    pld_i[0]  = '{addr: A0, data: 64'h1111_0000_0000_0001, strb: 8'hFF};
    pld_i[1]  = '{addr: A1, data: 64'h2222_0000_0000_0002, strb: 8'h0F};
    pld_i[2]  = '{addr: A2, data: 64'h3333_0000_0000_0003, strb: 8'hF0};

    repeat (3) cyc();
    check("rst:gnt", 64'(gnt_o), 64'd0);
    check("rst:done", 64'(done_o), 64'd0);
    check("rst:busy", 64'(busy_o), 64'd0);
    check("rst:bready", 64'(bready_o), 64'd0);
    check("rst:wd_err", 64'(wd_err_o), 64'd0);
    check("rst:wr_req", 64'(wr_req_o == '0), 64'd1);
    rst_ni = 1'b1;
    cyc();

    // Single write from client 0
    req_i    = 3'b001;
    wr_rdy_i = '1;
    cyc();
    check("single:awvalid", 64'(wr_req_o.awvalid), 64'd1);
    check("single:wvalid", 64'(wr_req_o.wvalid), 64'd1);
    check("single:gnt", 64'(gnt_o), 64'd1);
    check("single:addr", wr_req_o.addr, A0);
    check("single:data", wr_req_o.data, 64'h1111_0000_0000_0001);
    check("single:busy", 64'(busy_o), 64'd1);
    cyc();
    wr_rdy_i = '0;
    check("single:awvalid_off", 64'(wr_req_o.awvalid), 64'd0);
    check("single:bready", 64'(bready_o), 64'd1);
    cyc();
    cyc();
    check("single:no_done", 64'(done_o), 64'd0);
    wr_resp_i = '{bresp: 1'b0, bvalid: 1'b1};
    cyc();
    wr_resp_i = '0;
    check("single:done", 64'(done_o), 64'd1);
    check("single:bresp", 64'(bresp_o), 64'd0);
    check("single:busy_off", 64'(busy_o), 64'd0);
    check("single:bready_off", 64'(bready_o), 64'd0);
    req_i = 3'b000;
    cyc();
    check("single:done_pulse", 64'(done_o), 64'd0);

    // Contention from a fresh reset: rotation 0,1,2 then wrap to 0
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    req_i  = 3'b111;
    serve("rr0", 3'b001, A0, 1);
    serve("rr1", 3'b010, A1, 1);
    serve("rr2", 3'b100, A2, 1);
    serve("rr3", 3'b001, A0, 1);
    req_i = 3'b000;
    cyc();

    // Split handshake: W accepted at cycle 2, AW at cycle 5
    req_i = 3'b010;
    cyc();
    check("split:c1_aw", 64'(wr_req_o.awvalid), 64'd1);
    check("split:c1_w", 64'(wr_req_o.wvalid), 64'd1);
    check("split:c1_gnt", 64'(gnt_o), 64'd2);
    cyc();
    wr_rdy_i.wready = 1'b1;
    cyc();
    wr_rdy_i.wready = 1'b0;
    check("split:c3_w", 64'(wr_req_o.wvalid), 64'd0);
    check("split:c3_aw", 64'(wr_req_o.awvalid), 64'd1);
    cyc();
    check("split:c4_aw", 64'(wr_req_o.awvalid), 64'd1);
    cyc();
    check("split:c5_aw", 64'(wr_req_o.awvalid), 64'd1);
    check("split:c5_bready", 64'(bready_o), 64'd0);
    wr_rdy_i.awready = 1'b1;
    cyc();
    wr_rdy_i.awready = 1'b0;
    check("split:c6_aw", 64'(wr_req_o.awvalid), 64'd0);
    check("split:c6_bready", 64'(bready_o), 64'd1);
    wr_resp_i = '{bresp: 1'b1, bvalid: 1'b1};
    cyc();
    wr_resp_i = '0;
    check("split:done", 64'(done_o), 64'd2);
    check("split:bresp", 64'(bresp_o), 64'd1);
    req_i = 3'b000;
    cyc();

    // Stray B in IDLE and in ISSUE
    wr_resp_i = '{bresp: 1'b1, bvalid: 1'b1};
    cyc();
    wr_resp_i = '0;
    check("stray_idle:done", 64'(done_o), 64'd0);
    check("stray_idle:bready", 64'(bready_o), 64'd0);
    check("stray_idle:busy", 64'(busy_o), 64'd0);
    req_i = 3'b100;
    cyc();
    check("stray_issue:gnt", 64'(gnt_o), 64'd4);
    wr_resp_i = '{bresp: 1'b1, bvalid: 1'b1};
    cyc();
    wr_resp_i = '0;
    check("stray_issue:done", 64'(done_o), 64'd0);
    check("stray_issue:bready", 64'(bready_o), 64'd0);
    check("stray_issue:awvalid", 64'(wr_req_o.awvalid), 64'd1);
    check("stray_issue:busy", 64'(busy_o), 64'd1);
    wr_rdy_i = '1;
    cyc();
    wr_rdy_i = '0;
    check("stray_issue:bready_b", 64'(bready_o), 64'd1);
    wr_resp_i = '{bresp: 1'b1, bvalid: 1'b1};
    cyc();
    wr_resp_i = '0;
    check("stray_issue:done_b", 64'(done_o), 64'd4);
    check("stray_issue:bresp", 64'(bresp_o), 64'd1);
    req_i = 3'b000;
    cyc();

    // Watchdog: 16 WAIT_B cycles without B, then a late B
    req_i    = 3'b001;
    wr_rdy_i = '1;
    cyc();
    check("wd:gnt", 64'(gnt_o), 64'd1);
    cyc();
    wr_rdy_i = '0;
    check("wd:bready", 64'(bready_o), 64'd1);
    repeat (15) cyc();
    check("wd:not_yet", 64'(wd_err_o), 64'd0);
    cyc();
    check("wd:set", 64'(wd_err_o), 64'd1);
    check("wd:still_waiting", 64'(bready_o), 64'd1);
    repeat (2) cyc();
    wr_resp_i = '{bresp: 1'b0, bvalid: 1'b1};
    cyc();
    wr_resp_i = '0;
    check("wd:late_done", 64'(done_o), 64'd1);
    check("wd:sticky", 64'(wd_err_o), 64'd1);
    req_i = 3'b000;
    cyc();
    check("wd:sticky_idle", 64'(wd_err_o), 64'd1);

    // Reset mid-transaction; rr_ptr is 1 here, so a surviving pointer would pick client 1
    req_i = 3'b100;
    cyc();
    check("rst_mid:gnt", 64'(gnt_o), 64'd4);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid:gnt_off", 64'(gnt_o), 64'd0);
    check("rst_mid:wr_req", 64'(wr_req_o == '0), 64'd1);
    check("rst_mid:busy", 64'(busy_o), 64'd0);
    check("rst_mid:wd_err", 64'(wd_err_o), 64'd0);
    req_i = 3'b011;
    cyc();
    check("rst_mid:no_done", 64'(done_o), 64'd0);
    rst_ni = 1'b1;
    serve("rst_next", 3'b001, A0, 1);
    req_i = 3'b000;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
